// File: rtl/ahb_lite_interconnect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ahb_lite_interconnect                                      |
// | Description : AHB-Lite single-master interconnect. Combines the address  |
// |               decoder, the slave-to-master response mux and a default    |
// |               slave that answers unmapped accesses with a two-cycle      |
// |               ERROR. An optional per-transfer timeout aborts a hung      |
// |               slave with ERROR and fences that slave off (orphan) until  |
// |               it raises HREADYOUT again.                                 |
// | Option      : `define AHB_IC_TIMEOUT_EN to build the timeout counter,    |
// |               the orphan logic and TIMEOUT_IRQ/TIMEOUT_SLV.              |
// | Ports       : HCLK, HRESET (sync, active high)                           |
// |               HADDR/HTRANS        master address phase                   |
// |               HRDATA/HREADY/HRESP response to master (HREADY also to all |
// |                                   slaves)                                |
// |               HSEL                one-hot slave select                   |
// |               HRDATA_S/HREADYOUT_S/HRESP_S  slave responses              |
// |               TIMEOUT_IRQ/TIMEOUT_SLV       timeout pulse and slave index|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ahb_lite_interconnect #(
  parameter int           NUM_SLAVES     = 10,
  parameter logic [127:0] SLV_BASE       = {16{8'h00}},
  parameter logic [127:0] SLV_MASK       = {16{8'hFF}},
  parameter logic [31:0]  NOMAP_DATA     = 32'hDEADBEEF,
  parameter int           TIMEOUT_CYCLES = 1024
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  output logic [31:0]              HRDATA,
  output logic                     HREADY,
  output logic                     HRESP,
  output logic [NUM_SLAVES-1:0]    HSEL,
  input  logic [32*NUM_SLAVES-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]    HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]    HRESP_S,
  output logic                     TIMEOUT_IRQ,
  output logic [3:0]               TIMEOUT_SLV
);

  // The state register describes the current data phase, not the address
  // phase: ERR1/ERR2 are the two cycles of a default-slave ERROR response.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ERR1 = 2'd1,
    S_ERR2 = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_dact;
  logic        r_dsel_map;
  logic [3:0]  r_dsel_idx;

  logic        w_hit;
  logic [3:0]  w_hit_idx;
  logic        w_orph_hit;
  logic        w_dec_map;
  logic        w_timeout;
  logic        w_hready;
  logic        w_hresp;
  logic [31:0] w_hrdata;
  logic [15:0] w_rdy_pad;
  logic [15:0] w_resp_pad;
  logic [31:0] w_rdata_pad [16];
  logic        w_unused;

  // Only the top address byte and HTRANS[1] take part in decode.
  assign w_unused = ^{HADDR[23:0], HTRANS[0]};

  // Slave responses padded to 16 entries so a 4-bit index is always legal.
  always_comb begin
    w_rdy_pad  = '0;
    w_resp_pad = '0;
    for (int i = 0; i < 16; i++) w_rdata_pad[i] = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_rdy_pad[i]   = HREADYOUT_S[i];
      w_resp_pad[i]  = HRESP_S[i];
      w_rdata_pad[i] = HRDATA_S[32*i +: 32];
    end
  end

  // Scan from the top down so the lowest matching index is the one kept.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = 4'd0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((HADDR[31:24] & SLV_MASK[8*i +: 8]) == (SLV_BASE[8*i +: 8] & SLV_MASK[8*i +: 8])) begin
        w_hit     = 1'b1;
        w_hit_idx = 4'(i);
      end
    end
  end

  // An orphaned slave decodes as unmapped, so the default slave answers.
  assign w_dec_map = w_hit && !w_orph_hit;

  always_comb begin
    HSEL = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      HSEL[i] = w_dec_map && (w_hit_idx == 4'(i));
    end
  end

  // Response mux: error states override, otherwise a pure mux from dsel.
  always_comb begin
    w_hready = 1'b1;
    w_hresp  = 1'b0;
    w_hrdata = 32'd0;
    case (r_state)
      S_ERR1: begin
        w_hready = 1'b0;
        w_hresp  = 1'b1;
        w_hrdata = NOMAP_DATA;
      end
      S_ERR2: begin
        w_hready = 1'b1;
        w_hresp  = 1'b1;
        w_hrdata = NOMAP_DATA;
      end
      default: begin
        if (r_dact && r_dsel_map) begin
          w_hready = w_rdy_pad[r_dsel_idx];
          w_hresp  = w_resp_pad[r_dsel_idx];
          w_hrdata = w_rdata_pad[r_dsel_idx];
        end
      end
    endcase
  end

  assign HREADY = w_hready;
  assign HRESP  = w_hresp;
  assign HRDATA = w_hrdata;

  // Data-phase register and error FSM. An unmapped address sampled in IDLE
  // or ERR2 enters ERR1 at the same edge its data phase begins, so the
  // ERROR takes exactly two data-phase cycles with no bubble in between.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state    <= S_IDLE;
      r_dact     <= 1'b0;
      r_dsel_map <= 1'b0;
      r_dsel_idx <= 4'd0;
    end else begin
      if (w_hready) begin
        r_dact     <= HTRANS[1];
        r_dsel_map <= w_dec_map;
        r_dsel_idx <= w_hit_idx;
      end
      case (r_state)
        S_IDLE: begin
          if ((w_hready && HTRANS[1] && !w_dec_map) || w_timeout) r_state <= S_ERR1;
        end
        S_ERR1: r_state <= S_ERR2;
        S_ERR2: r_state <= (HTRANS[1] && !w_dec_map) ? S_ERR1 : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef AHB_IC_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_orph_vld;
  logic [3:0]  r_orph_idx;
  logic        r_irq;
  logic [3:0]  r_tslv;
  logic        w_wait;

  assign w_wait     = (r_state == S_IDLE) && r_dact && r_dsel_map && !w_rdy_pad[r_dsel_idx];
  // Fires on the last allowed wait cycle so ERR1 follows directly.
  assign w_timeout  = w_wait && (r_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign w_orph_hit = r_orph_vld && (r_orph_idx == w_hit_idx);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_cnt      <= 16'd0;
      r_orph_vld <= 1'b0;
      r_orph_idx <= 4'd0;
      r_irq      <= 1'b0;
      r_tslv     <= 4'd0;
    end else begin
      r_irq <= w_timeout;
      if (w_timeout) begin
        r_cnt      <= 16'd0;
        r_tslv     <= r_dsel_idx;
        r_orph_vld <= 1'b1;
        r_orph_idx <= r_dsel_idx;
      end else begin
        r_cnt <= w_wait ? r_cnt + 16'd1 : 16'd0;
        if (r_orph_vld && w_rdy_pad[r_orph_idx]) r_orph_vld <= 1'b0;
      end
    end
  end

  assign TIMEOUT_IRQ = r_irq;
  assign TIMEOUT_SLV = r_tslv;
`else
  assign w_timeout   = 1'b0;
  assign w_orph_hit  = 1'b0;
  assign TIMEOUT_IRQ = 1'b0;
  assign TIMEOUT_SLV = 4'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_interconnect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ahb_lite_interconnect                                   |
// | Description : Self-checking bench for ahb_lite_interconnect: decode     |
// |               vector table, directed and random transfers against a      |
// |               transaction-level model, reset abort, and timeout (with    |
// |               AHB_IC_TIMEOUT_EN) or indefinite stall (without).          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ahb_lite_interconnect;
  localparam int NS = 8;
  localparam logic [127:0] C_BASE = {64'h0, 8'h08, 8'hC0, 8'h80, 8'h60, 8'h40, 8'h40, 8'h20, 8'h00};
  localparam logic [127:0] C_MASK = {64'hFFFF_FFFF_FFFF_FFFF, 8'hF8, 8'hFF, 8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hF0, 8'hFF};

  logic            HCLK = 1'b0;
  logic            HRESET = 1'b1;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic [31:0]     HRDATA;
  logic            HREADY;
  logic            HRESP;
  logic [NS-1:0]   HSEL;
  logic [32*NS-1:0] HRDATA_S;
  logic [NS-1:0]   HREADYOUT_S;
  logic [NS-1:0]   HRESP_S;
  logic            TIMEOUT_IRQ;
  logic [3:0]      TIMEOUT_SLV;

  ahb_lite_interconnect #(
    .NUM_SLAVES(NS), .SLV_BASE(C_BASE), .SLV_MASK(C_MASK),
    .NOMAP_DATA(32'hDEADBEEF), .TIMEOUT_CYCLES(8)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .HSEL(HSEL),
    .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
    .TIMEOUT_IRQ(TIMEOUT_IRQ), .TIMEOUT_SLV(TIMEOUT_SLV)
  );

  always #5 HCLK = ~HCLK;

  int n_err = 0;
  int n_chk = 0;

  // Reference address map, written independently of the packed parameters.
  logic [7:0] m_base [NS] = '{8'h00, 8'h20, 8'h40, 8'h40, 8'h60, 8'h80, 8'hC0, 8'h08};
  logic [7:0] m_mask [NS] = '{8'hFF, 8'hF0, 8'hFF, 8'hFF, 8'hFF, 8'hC0, 8'hFF, 8'hF8};

  typedef struct {
    logic [31:0] addr;
    bit          act;
    int          waits;
    bit          serr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [7:0]  hsel;
  } vec_t;

  txn_t tq[$];
  vec_t vt[13];

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a[31:24] & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
    return -1;
  endfunction

  function automatic logic [NS-1:0] onehot(input int s);
    logic [NS-1:0] v;
    v = '0;
    if (s >= 0) v[s] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic slaves_idle();
    HREADYOUT_S = '1;
    HRESP_S     = '0;
    for (int i = 0; i < NS; i++) HRDATA_S[32*i +: 32] = $urandom;
  endtask

  // Drives the transfers in tq with pipelined address/data phases and
  // checks every cycle against the transaction-level expectation.
  task automatic run_q();
    bit          have_d;
    txn_t        d;
    int          k, a, s;
    logic        e_rdy, e_resp;
    logic [31:0] e_data;
    bit          c_data;
    have_d = 0; k = 0; a = 0;
    while (a < tq.size() || have_d) begin
      @(posedge HCLK); #1;
      if (a < tq.size()) begin
        HADDR  = tq[a].addr;
        HTRANS = tq[a].act ? 2'b10 : 2'b00;
      end else begin
        HADDR  = $urandom;
        HTRANS = 2'b00;
      end
      slaves_idle();
      e_rdy = 1'b1; e_resp = 1'b0; e_data = 32'd0; c_data = 1;
      if (have_d && d.act) begin
        s = decode(d.addr);
        if (s < 0) begin
          if (k == 0) begin
            e_rdy = 1'b0; e_resp = 1'b1; e_data = 32'hDEADBEEF;
          end else begin
            e_rdy = 1'b1; e_resp = 1'b1; c_data = 0;
          end
        end else begin
          e_rdy  = d.serr ? (k > d.waits) : (k >= d.waits);
          e_resp = d.serr && (k >= d.waits);
          e_data = d.data;
          HREADYOUT_S[s]       = e_rdy;
          HRESP_S[s]           = e_resp;
          HRDATA_S[32*s +: 32] = d.data;
        end
      end
      @(negedge HCLK);
      chk("hsel", 32'(HSEL), 32'(onehot(decode(HADDR))));
      chk("hready", 32'(HREADY), 32'(e_rdy));
      chk("hresp", 32'(HRESP), 32'(e_resp));
      if (c_data) chk("hrdata", HRDATA, e_data);
      if (e_rdy) begin
        if (a < tq.size()) begin
          d = tq[a]; have_d = 1; a++;
        end else begin
          have_d = 0;
        end
        k = 0;
      end else begin
        k++;
      end
    end
  endtask

  initial begin
    txn_t t;
    int   bad;
    vt[0]  = '{32'h0000_0000, 2'b10, 8'h01};
    vt[1]  = '{32'h0800_1234, 2'b00, 8'h80};
    vt[2]  = '{32'h0F00_0000, 2'b01, 8'h80};
    vt[3]  = '{32'h1000_0000, 2'b00, 8'h00};
    vt[4]  = '{32'h2000_0004, 2'b11, 8'h02};
    vt[5]  = '{32'h2F00_0000, 2'b00, 8'h02};
    vt[6]  = '{32'h4000_0000, 2'b10, 8'h04};
    vt[7]  = '{32'h6000_0000, 2'b00, 8'h10};
    vt[8]  = '{32'h8000_0000, 2'b01, 8'h20};
    vt[9]  = '{32'hBF00_0000, 2'b00, 8'h20};
    vt[10] = '{32'hC000_0000, 2'b10, 8'h40};
    vt[11] = '{32'hF000_0000, 2'b00, 8'h00};
    vt[12] = '{32'h4100_0000, 2'b00, 8'h00};

    HADDR = 32'd0; HTRANS = 2'b00;
    slaves_idle();
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_irq", 32'(TIMEOUT_IRQ), 32'd0);
    chk("rst_tslv", 32'(TIMEOUT_SLV), 32'd0);

    // Decode table: HSEL must follow HADDR in the same cycle, any HTRANS.
    for (int i = 0; i < 13; i++) begin
      @(posedge HCLK); #1;
      HADDR = vt[i].addr; HTRANS = vt[i].trans;
      slaves_idle();
      @(negedge HCLK);
      chk("dec_table", 32'(HSEL), 32'(vt[i].hsel));
    end
    @(posedge HCLK); #1 HTRANS = 2'b00;
    repeat (3) @(posedge HCLK);

    // Directed: 1-wait read, unmapped ERROR, back-to-back, slave ERROR.
    tq.delete();
    tq.push_back('{32'h2000_0004, 1'b1, 1, 1'b0, 32'h1234_5678});
    tq.push_back('{32'hF000_0000, 1'b1, 0, 1'b0, 32'h0});
    tq.push_back('{32'h0000_0010, 1'b1, 0, 1'b0, 32'hCAFE_0001});
    tq.push_back('{32'h4000_0000, 1'b1, 2, 1'b1, 32'h0000_0044});
    tq.push_back('{32'h8000_0000, 1'b0, 0, 1'b0, 32'h0});
    tq.push_back('{32'hF100_0000, 1'b1, 0, 1'b0, 32'h0});
    tq.push_back('{32'h1000_0000, 1'b1, 0, 1'b0, 32'h0});
    tq.push_back('{32'hC000_0000, 1'b1, 0, 1'b0, 32'h0000_0066});
    run_q();

    // Random traffic against the model.
    tq.delete();
    for (int i = 0; i < 200; i++) begin
      t.addr = $urandom;
      if ($urandom_range(0, 1) == 1) t.addr[31:24] = m_base[$urandom_range(0, NS - 1)];
      t.act   = ($urandom_range(0, 3) != 0);
      t.waits = $urandom_range(0, 3);
      t.serr  = ($urandom_range(0, 7) == 0);
      t.data  = $urandom;
      tq.push_back(t);
    end
    run_q();

    // Reset in the middle of a wait state abandons the transfer.
    @(posedge HCLK); #1;
    HADDR = 32'h2000_0000; HTRANS = 2'b10; slaves_idle();
    @(posedge HCLK); #1;
    HADDR = 32'h0; HTRANS = 2'b00;
    HREADYOUT_S[1] = 1'b0; HRDATA_S[63:32] = 32'hAAAA_5555;
    @(negedge HCLK);
    chk("rstw_stall", 32'(HREADY), 32'd0);
    chk("rstw_data", HRDATA, 32'hAAAA_5555);
    @(posedge HCLK); #1 HRESET = 1'b1;
    @(posedge HCLK); #1 HRESET = 1'b0;
    @(negedge HCLK);
    chk("rstw_hready", 32'(HREADY), 32'd1);
    chk("rstw_hresp", 32'(HRESP), 32'd0);
    chk("rstw_hrdata", HRDATA, 32'd0);
    @(posedge HCLK); #1 slaves_idle();
    @(negedge HCLK);
    chk("rstw_idle", 32'(HREADY), 32'd1);

`ifdef AHB_IC_TIMEOUT_EN
    @(posedge HCLK); #1;
    HADDR = 32'h6000_0000; HTRANS = 2'b10; slaves_idle();
    @(negedge HCLK);
    chk("to_hsel", 32'(HSEL), 32'h10);
    @(posedge HCLK); #1;
    HADDR = 32'h0; HTRANS = 2'b00; HREADYOUT_S[4] = 1'b0;
    for (int w = 0; w < 8; w++) begin
      @(negedge HCLK);
      chk("to_wait_rdy", 32'(HREADY), 32'd0);
      chk("to_wait_resp", 32'(HRESP), 32'd0);
      chk("to_wait_irq", 32'(TIMEOUT_IRQ), 32'd0);
      @(posedge HCLK); #1;
    end
    HADDR = 32'h6000_0000; HTRANS = 2'b10;
    @(negedge HCLK);
    chk("to_e1_rdy", 32'(HREADY), 32'd0);
    chk("to_e1_resp", 32'(HRESP), 32'd1);
    chk("to_e1_data", HRDATA, 32'hDEADBEEF);
    chk("to_e1_irq", 32'(TIMEOUT_IRQ), 32'd1);
    chk("to_e1_slv", 32'(TIMEOUT_SLV), 32'd4);
    chk("to_e1_hsel", 32'(HSEL), 32'd0);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("to_e2_rdy", 32'(HREADY), 32'd1);
    chk("to_e2_resp", 32'(HRESP), 32'd1);
    chk("to_e2_irq", 32'(TIMEOUT_IRQ), 32'd0);
    chk("to_e2_hsel", 32'(HSEL), 32'd0);
    @(posedge HCLK); #1 HTRANS = 2'b00;
    @(negedge HCLK);
    chk("orph_e1_rdy", 32'(HREADY), 32'd0);
    chk("orph_e1_resp", 32'(HRESP), 32'd1);
    chk("orph_e1_data", HRDATA, 32'hDEADBEEF);
    chk("orph_e1_irq", 32'(TIMEOUT_IRQ), 32'd0);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("orph_e2_rdy", 32'(HREADY), 32'd1);
    chk("orph_e2_resp", 32'(HRESP), 32'd1);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("orph_hsel", 32'(HSEL), 32'd0);
    chk("orph_idle_resp", 32'(HRESP), 32'd0);
    @(posedge HCLK); #1 HREADYOUT_S[4] = 1'b1;
    @(negedge HCLK);
    chk("orph_hsel_rel", 32'(HSEL), 32'd0);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("orph_cleared", 32'(HSEL), 32'h10);
    chk("orph_tslv", 32'(TIMEOUT_SLV), 32'd4);
`else
    @(posedge HCLK); #1;
    HADDR = 32'h6000_0000; HTRANS = 2'b10; slaves_idle();
    @(posedge HCLK); #1;
    HADDR = 32'h0; HTRANS = 2'b00; HREADYOUT_S[4] = 1'b0;
    bad = 0;
    for (int w = 0; w < 2000; w++) begin
      @(negedge HCLK);
      if (HREADY !== 1'b0 || HRESP !== 1'b0 || TIMEOUT_IRQ !== 1'b0) bad++;
      @(posedge HCLK); #1;
    end
    chk("stall_bad_cycles", 32'(bad), 32'd0);
    HREADYOUT_S[4] = 1'b1;
    @(negedge HCLK);
    chk("stall_release_rdy", 32'(HREADY), 32'd1);
    chk("stall_release_resp", 32'(HRESP), 32'd0);
    chk("stall_irq", 32'(TIMEOUT_IRQ), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
